// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the shift sequencer: widths, op encodings, FSM states.
// The rotate feature is selected with the SHIFT_SEQ_ROTATE_EN macro in shift_sequencer.sv.
package shift_sequencer_pkg;

   localparam int unsigned SHIFT_W = 32;
   localparam int unsigned AMT_W   = 5;

   typedef enum logic [1:0] {
      OpSll = 2'b00,
      OpSrl = 2'b01,
      OpSra = 2'b10,
      OpRol = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      StIdle,
      StPass1,
      StPass2,
      StDone
   } state_e;

   // (32 - amt) truncated to 5 bits; only meaningful for amt != 0.
   function automatic logic [AMT_W-1:0] rol_back_amt(input logic [AMT_W-1:0] amt);
      logic [AMT_W:0] diff;
      diff = (AMT_W + 1)'(SHIFT_W) - {1'b0, amt};
      return diff[AMT_W-1:0];
   endfunction

endpackage

// File: rtl/bit_reverse_32.sv
// Purely combinational 32-bit bit reversal, used around the left shifter to
// turn right shifts into left shifts.
module bit_reverse_32
   import shift_sequencer_pkg::*;
(
   input  logic [SHIFT_W-1:0] data_i,
   output logic [SHIFT_W-1:0] data_o
);

   // Mirror bit i onto bit 31-i.
   always_comb begin
      data_o = '0;
      for (int i = 0; i < SHIFT_W; i++) begin
         data_o[i] = data_i[SHIFT_W-1-i];
      end
   end

endmodule

// File: rtl/shift_sequencer.sv
// Shared-shifter sequencer: arbitrates one 32-bit left barrel shifter between
// the execute stage (port 0) and the multdiv unit (port 1), performing SLL,
// SRL, SRA and optionally ROL in one or two passes.
// Macro SHIFT_SEQ_ROTATE_EN: when defined, op 11 is a true rotate-left; when
// undefined, op 11 runs as SLL in a single pass and reports rsp_err.
module shift_sequencer
   import shift_sequencer_pkg::*;
#(
   parameter logic RESET_LAST_GRANT = 1'b1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [1:0]         req_valid,
   output logic [1:0]         req_ready,
   input  logic [SHIFT_W-1:0] req_data_0,
   input  logic [SHIFT_W-1:0] req_data_1,
   input  logic [AMT_W-1:0]   req_amt_0,
   input  logic [AMT_W-1:0]   req_amt_1,
   input  logic [1:0]         req_op_0,
   input  logic [1:0]         req_op_1,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic               rsp_id,
   output logic [SHIFT_W-1:0] rsp_data,
   output logic               rsp_err
);

   state_e             state_q, state_d;
   logic               last_grant_q, last_grant_d;
   logic [SHIFT_W-1:0] data_q, data_d;
   logic [AMT_W-1:0]   amt_q, amt_d;
   op_e                op_q, op_d;
   logic               id_q, id_d;
   logic [SHIFT_W-1:0] result_q, result_d;
   logic               err_q, err_d;

   logic               grant;
   logic               accept;
   logic               need_pass2;
   logic [SHIFT_W-1:0] rev_data;
   logic [SHIFT_W-1:0] shift_in;
   logic [AMT_W-1:0]   shift_amt;
   logic [SHIFT_W-1:0] shift_out;
   logic [SHIFT_W-1:0] rev_out;

   bit_reverse_32 u_rev_data (
      .data_i (data_q),
      .data_o (rev_data)
   );

   bit_reverse_32 u_rev_out (
      .data_i (shift_out),
      .data_o (rev_out)
   );

   // Arbitration: a lone requester wins; a tie goes to the port not served last.
   always_comb begin
      case (req_valid)
         2'b01:   grant = 1'b0;
         2'b10:   grant = 1'b1;
         default: grant = ~last_grant_q;
      endcase
      accept = |(req_valid & req_ready);
   end

   // Select shifter input and amount for the current pass.
   always_comb begin
      shift_in  = data_q;
      shift_amt = amt_q;
      case (state_q)
         StPass1: begin
            if (op_q == OpSrl || op_q == OpSra) shift_in = rev_data;
         end
         StPass2: begin
            if (op_q == OpSra) shift_in = '1;
`ifdef SHIFT_SEQ_ROTATE_EN
            else begin
               shift_in  = rev_data;
               shift_amt = rol_back_amt(amt_q);
            end
`endif
         end
         default: ;
      endcase
   end

   // The single shared left barrel shifter.
   always_comb begin
      shift_out = shift_in << shift_amt;
   end

   // Decide after PASS1 whether a second pass is required.
   always_comb begin
      need_pass2 = 1'b0;
      if (op_q == OpSra) need_pass2 = data_q[SHIFT_W-1] && (amt_q != '0);
`ifdef SHIFT_SEQ_ROTATE_EN
      if (op_q == OpRol) need_pass2 = (amt_q != '0);
`endif
   end

   // FSM state register.
   always_ff @(posedge clock) begin
      if (reset) state_q <= StIdle;
      else       state_q <= state_d;
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (accept) state_d = StPass1;
         StPass1: state_d = need_pass2 ? StPass2 : StDone;
         StPass2: state_d = StDone;
         StDone:  if (rsp_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs: ready only in IDLE toward the granted port, valid only in DONE.
   always_comb begin
      req_ready = 2'b00;
      if (state_q == StIdle) req_ready[grant] = 1'b1;
      rsp_valid = (state_q == StDone);
   end

   // Datapath next-state: capture request on accept, build result per pass.
   always_comb begin
      last_grant_d = last_grant_q;
      data_d       = data_q;
      amt_d        = amt_q;
      op_d         = op_q;
      id_d         = id_q;
      result_d     = result_q;
      err_d        = err_q;
      case (state_q)
         StIdle: begin
            if (accept) begin
               data_d       = grant ? req_data_1 : req_data_0;
               amt_d        = grant ? req_amt_1 : req_amt_0;
               op_d         = op_e'(grant ? req_op_1 : req_op_0);
               id_d         = grant;
               last_grant_d = grant;
            end
         end
         StPass1: begin
            result_d = (op_q == OpSrl || op_q == OpSra) ? rev_out : shift_out;
`ifdef SHIFT_SEQ_ROTATE_EN
            err_d = 1'b0;
`else
            err_d = (op_q == OpRol);
`endif
         end
         StPass2: begin
            // SRA ORs in the sign fill; ROL ORs in the wrapped-around bits.
            result_d = (op_q == OpSra) ? (result_q | ~rev_out) : (result_q | rev_out);
         end
         default: ;
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         last_grant_q <= RESET_LAST_GRANT;
         data_q       <= '0;
         amt_q        <= '0;
         op_q         <= OpSll;
         id_q         <= 1'b0;
         result_q     <= '0;
         err_q        <= 1'b0;
      end else begin
         last_grant_q <= last_grant_d;
         data_q       <= data_d;
         amt_q        <= amt_d;
         op_q         <= op_d;
         id_q         <= id_d;
         result_q     <= result_d;
         err_q        <= err_d;
      end
   end

   assign rsp_id   = id_q;
   assign rsp_data = result_q;
   assign rsp_err  = err_q;

endmodule
